// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-requester RAM arbiter with
// built-in clear sequence.
package ram_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 6;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request is granted directly, a tie goes
// to the side named by pointer (0 = A, 1 = B).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = pointer ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single-port-per-direction RAM and clears
// the whole RAM after reset or on init_req.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              init_req,
    output logic              init_busy,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_read_en,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_read_data
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              pointer;
    logic              arb_open;
    logic              clr_last;
    logic [1:0]        gnt;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // init_req and rst both pre-empt any request in the same cycle
    assign arb_open = !rst && (state == ARB) && !init_req;
    assign clr_last = (clr_cnt == {ADDR_W{1'b1}});

    rr_arb2 u_pick (
        .req     ({b_req, a_req} & {2{arb_open}}),
        .pointer (pointer),
        .gnt     (gnt)
    );

    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];
    assign win_we    = gnt[1] ? b_we    : a_we;
    assign win_addr  = gnt[1] ? b_addr  : a_addr;
    assign win_wdata = gnt[1] ? b_wdata : a_wdata;
    assign init_busy = (state == INIT);
    assign rdata     = (a_rvalid || b_rvalid) ? ram_read_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (clr_last) state_nxt = ARB;
            ARB:     if (init_req) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        ram_write_en   = 1'b0;
        ram_write_addr = '0;
        ram_write_data = '0;
        ram_read_en    = 1'b0;
        ram_read_addr  = '0;
        if (!rst) begin
            if (state == INIT) begin
                ram_write_en   = 1'b1;
                ram_write_addr = clr_cnt;
            end else if (|gnt) begin
                if (win_we) begin
                    ram_write_en   = 1'b1;
                    ram_write_addr = win_addr;
                    ram_write_data = win_wdata;
                end else begin
                    ram_read_en   = 1'b1;
                    ram_read_addr = win_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            clr_cnt  <= '0;
            pointer  <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            state <= state_nxt;
            // counter idles at zero outside INIT so every INIT entry starts at 0
            clr_cnt <= (state == INIT && !clr_last) ? clr_cnt + 1'b1 : '0;
            if (|gnt) pointer <= gnt[0];
            a_rvalid <= gnt[0] && !a_we;
            b_rvalid <= gnt[1] && !b_we;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed-vector bench for ram_arbiter with a small registered-read RAM
// model attached to the write/read ports.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0, init_req = 0;
    logic [7:0] a_addr = 0, b_addr = 0;
    logic [5:0] a_wdata = 0, b_wdata = 0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, init_busy;
    logic [5:0] rdata;
    logic       ram_write_en, ram_read_en;
    logic [7:0] ram_write_addr, ram_read_addr;
    logic [5:0] ram_write_data;
    logic [5:0] ram_read_data = 0;
    logic [5:0] mem [256];
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(6)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .init_req(init_req), .init_busy(init_busy),
        .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data),
        .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr),
        .ram_read_data(ram_read_data)
    );

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        if (ram_read_en) ram_read_data <= mem[ram_read_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle before the rise.
    task automatic drive(input logic r, input logic ir,
                         input logic ar, input logic aw, input logic [7:0] aa, input logic [5:0] ad,
                         input logic br, input logic bw, input logic [7:0] ba, input logic [5:0] bd);
        @(negedge clk);
        rst = r; init_req = ir;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 8'h00, 6'h00, 0, 0, 8'h00, 6'h00);
    endtask

    task automatic wait_init_done(input string tag);
        for (int i = 0; i < 300 && init_busy; i++) idle();
        check(tag, init_busy, 0);
    endtask

    initial begin
        // reset hold
        drive(1, 0, 0, 0, 8'h00, 6'h00, 0, 0, 8'h00, 6'h00);
        drive(1, 0, 0, 0, 8'h00, 6'h00, 0, 0, 8'h00, 6'h00);
        check("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
        check("rst_rdata", rdata, 0);
        check("rst_en", {ram_write_en, ram_read_en}, 2'b00);

        // clear sequence after reset release
        for (int k = 0; k < 256; k++) begin
            idle();
            check("clear_write", {ram_write_en, ram_read_en, ram_write_addr, ram_write_data, a_gnt, b_gnt},
                  {1'b1, 1'b0, 8'(k), 6'h00, 2'b00});
        end
        idle();
        check("clear_done", init_busy, 0);

        // A writes 0x2A @0x10, B reads it back
        drive(0, 0, 1, 1, 8'h10, 6'h2A, 0, 0, 8'h00, 6'h00);
        check("a_wr_gnt", {a_gnt, b_gnt}, 2'b10);
        check("a_wr_port", {ram_write_en, ram_read_en, ram_write_addr, ram_write_data}, {2'b10, 8'h10, 6'h2A});
        drive(0, 0, 0, 0, 8'h00, 6'h00, 1, 0, 8'h10, 6'h00);
        check("b_rd_gnt", {a_gnt, b_gnt}, 2'b01);
        check("b_rd_port", {ram_write_en, ram_read_en, ram_read_addr}, {2'b01, 8'h10});
        check("wr_no_rvalid", a_rvalid, 0);
        idle();
        check("b_rvalid", {a_rvalid, b_rvalid}, 2'b01);
        check("b_rdata", rdata, 6'h2A);
        check("idle_port", {ram_write_en, ram_read_en, ram_write_addr, ram_read_addr}, 0);
        idle();
        check("b_rvalid_drop", b_rvalid, 0);

        // both request: alternation starting with A (B was last winner)
        drive(0, 0, 1, 0, 8'h10, 6'h00, 1, 0, 8'h20, 6'h00);
        check("alt1", {a_gnt, b_gnt}, 2'b10);
        drive(0, 0, 1, 0, 8'h10, 6'h00, 1, 0, 8'h20, 6'h00);
        check("alt2", {a_gnt, b_gnt}, 2'b01);
        check("alt2_rd", {a_rvalid, b_rvalid, rdata}, {2'b10, 6'h2A});
        drive(0, 0, 1, 0, 8'h10, 6'h00, 1, 0, 8'h20, 6'h00);
        check("alt3", {a_gnt, b_gnt}, 2'b10);
        check("alt3_rd", {a_rvalid, b_rvalid, rdata}, {2'b01, 6'h00});
        drive(0, 0, 1, 0, 8'h10, 6'h00, 1, 0, 8'h20, 6'h00);
        check("alt4", {a_gnt, b_gnt}, 2'b01);
        idle();
        check("alt4_rd", {a_rvalid, b_rvalid, rdata}, {2'b01, 6'h00});

        // B alone for three back-to-back writes, then read one back
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 8'h00, 6'h00, 1, 1, 8'(8'h21 + k), 6'(6'h15 + k));
            check("b_only", {a_gnt, b_gnt, ram_write_en, ram_write_addr}, {3'b011, 8'(8'h21 + k)});
        end
        drive(0, 0, 0, 0, 8'h00, 6'h00, 1, 0, 8'h22, 6'h00);
        idle();
        check("b_only_rd", {b_rvalid, rdata}, {1'b1, 6'h16});

        // A read then init_req (with competing B request) the next cycle
        drive(0, 0, 1, 0, 8'h10, 6'h00, 0, 0, 8'h00, 6'h00);
        check("pre_init_gnt", a_gnt, 1);
        drive(0, 1, 0, 0, 8'h00, 6'h00, 1, 0, 8'h22, 6'h00);
        check("init_wins", {a_gnt, b_gnt, ram_write_en, ram_read_en}, 4'b0000);
        check("pre_init_rd", {a_rvalid, rdata}, {1'b1, 6'h2A});
        idle();
        check("init_entry", {init_busy, ram_write_en, ram_write_addr, a_rvalid}, {2'b11, 8'h00, 1'b0});
        for (int k = 1; k < 10; k++) idle();
        drive(0, 1, 1, 0, 8'h10, 6'h00, 0, 0, 8'h00, 6'h00);
        check("init_ignore", {a_gnt, ram_write_addr}, {1'b0, 8'd10});
        idle();
        check("init_no_restart", ram_write_addr, 8'd11);
        wait_init_done("reinit_done");
        drive(0, 0, 1, 0, 8'h10, 6'h00, 0, 0, 8'h00, 6'h00);
        idle();
        check("cleared_rd", {a_rvalid, rdata}, {1'b1, 6'h00});

        // reset on the cycle of a read request: nothing granted, no rvalid
        drive(1, 0, 1, 0, 8'h10, 6'h00, 0, 0, 8'h00, 6'h00);
        check("rst_no_gnt", {a_gnt, ram_read_en}, 2'b00);
        drive(1, 0, 0, 0, 8'h00, 6'h00, 0, 0, 8'h00, 6'h00);
        check("rst_no_rvalid", {a_rvalid, rdata}, 7'h00);

        // reset mid-INIT at counter 100 restarts the clear from 0
        for (int k = 0; k <= 100; k++) idle();
        check("mid_init_100", ram_write_addr, 8'd100);
        drive(1, 0, 0, 0, 8'h00, 6'h00, 0, 0, 8'h00, 6'h00);
        check("mid_init_rst_en", ram_write_en, 0);
        idle();
        check("restart_0", {ram_write_en, ram_write_addr}, {1'b1, 8'd0});
        idle();
        check("restart_1", ram_write_addr, 8'd1);
        wait_init_done("restart_done");

        // pointer back to A after reset
        drive(0, 0, 1, 0, 8'h00, 6'h00, 1, 0, 8'h01, 6'h00);
        check("ptr_reset_a", {a_gnt, b_gnt}, 2'b10);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
